// File: rtl/usb_pkg.sv
// Shared types and constants for the packet serializer: CRC mode encoding,
// CRC5/CRC16 polynomials and seeds, and the serializer FSM state type.
package usb_pkg;

  typedef enum logic [1:0] {
    CRC_NONE = 2'b00,
    CRC_5    = 2'b01,
    CRC_16   = 2'b10,
    CRC_RSVD = 2'b11
  } crc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CRC   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Polynomials are written without the implicit x^W term.
  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic crc_active(input crc_mode_e mode);
    return (mode == CRC_5) || (mode == CRC_16);
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// Bit-serial CRC shift register (MSB-first, Galois form). Only built when
// PKT_SERIALIZER_CRC_EN is defined.
`ifdef PKT_SERIALIZER_CRC_EN
module crc_lfsr #(
  parameter int             W    = 5,
  parameter logic [W-1:0]   POLY = '0,
  parameter logic [W-1:0]   INIT = '1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] crc_out
);

  logic [W-1:0] r_crc;
  logic         w_fb;

  assign w_fb = bit_in ^ r_crc[W-1];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_crc <= INIT;
    end else if (clr) begin
      r_crc <= INIT;
    end else if (en) begin
      r_crc <= {r_crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

  assign crc_out = r_crc;

endmodule
`endif

// File: rtl/pkt_serializer.sv
// Serializes a right-justified packet MSB-first, optionally followed by a
// complemented CRC5/CRC16 trailer (built only with PKT_SERIALIZER_CRC_EN).
module pkt_serializer
  import usb_pkg::*;
#(
  parameter int MAX_W = 99,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  output logic             ready,
  input  logic [MAX_W-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] crc_skip,
  input  logic [1:0]       crc_mode,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_W);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_e           r_state;
  state_e           w_next;
  logic [MAX_W-1:0] r_data;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_pos;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_data_bit;
  logic             w_crc_on;

  // Abort wins over load in IDLE, so a simultaneous pair is never accepted.
  assign w_accept   = (r_state == ST_IDLE) && load && (len != '0) && !abort;
  assign w_len_eff  = (len > MAX_LEN) ? MAX_LEN : len;
  assign w_pos      = r_len - ONE - r_idx;
  assign w_last_bit = (r_idx == (r_len - ONE));
  assign w_data_bit = r_data[w_pos];

`ifdef PKT_SERIALIZER_CRC_EN
  logic [LEN_W-1:0] r_skip;
  crc_mode_e        r_mode;
  logic [3:0]       r_crc_cnt;
  logic [4:0]       w_crc5;
  logic [15:0]      w_crc16;
  logic             w_feed;
  logic             w_crc_last;
  logic             w_crc_bit;

  assign w_feed = (r_state == ST_SHIFT) && (r_idx >= r_skip);

  crc_lfsr #(
    .W    (5),
    .POLY (CRC5_POLY),
    .INIT (CRC5_INIT)
  ) u_crc5 (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (w_accept),
    .en      (w_feed && (r_mode == CRC_5)),
    .bit_in  (w_data_bit),
    .crc_out (w_crc5)
  );

  crc_lfsr #(
    .W    (16),
    .POLY (CRC16_POLY),
    .INIT (CRC16_INIT)
  ) u_crc16 (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (w_accept),
    .en      (w_feed && (r_mode == CRC_16)),
    .bit_in  (w_data_bit),
    .crc_out (w_crc16)
  );

  assign w_crc_on   = crc_active(r_mode);
  assign w_crc_last = (r_mode == CRC_5) ? (r_crc_cnt == 4'd4) : (r_crc_cnt == 4'd15);
  assign w_crc_bit  = (r_mode == CRC_5) ? w_crc5[3'd4 - r_crc_cnt[2:0]]
                                        : w_crc16[4'd15 - r_crc_cnt];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_skip    <= '0;
      r_mode    <= CRC_NONE;
      r_crc_cnt <= '0;
    end else if (w_accept) begin
      r_skip    <= crc_skip;
      r_mode    <= crc_mode_e'(crc_mode);
      r_crc_cnt <= '0;
    end else if (r_state == ST_CRC) begin
      r_crc_cnt <= r_crc_cnt + 4'd1;
    end
  end
`else
  logic w_unused_crc;

  assign w_crc_on     = 1'b0;
  assign w_unused_crc = ^{crc_skip, crc_mode};
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: the packet register is ordinary flops, not a RAM, so it is cleared
  // on reset like every other register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_data <= '0;
      r_len  <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_data <= data;
      r_len  <= w_len_eff;
      r_idx  <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_idx  <= r_idx + ONE;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    ready     = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (w_accept) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = w_data_bit;
        if (w_last_bit) w_next = w_crc_on ? ST_CRC : ST_DONE;
      end
`ifdef PKT_SERIALIZER_CRC_EN
      ST_CRC: begin
        bit_valid = 1'b1;
        bit_out   = ~w_crc_bit;
        if (w_crc_last) w_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

endmodule

// File: tb/tb_pkt_serializer.sv
// Scoreboard bench for pkt_serializer: expected serial bits are queued when a
// packet is loaded and popped as the DUT emits valid bits.
module tb_pkt_serializer;

  localparam int MAX_W = 99;
  localparam int LEN_W = 7;
`ifdef PKT_SERIALIZER_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_b;
  logic             load;
  logic             ready;
  logic [MAX_W-1:0] data;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] crc_skip;
  logic [1:0]       crc_mode;
  logic             abort;
  logic             bit_out;
  logic             bit_valid;
  logic             done;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  pkt_serializer #(
    .MAX_W (MAX_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (load),
    .ready     (ready),
    .data      (data),
    .len       (len),
    .crc_skip  (crc_skip),
    .crc_mode  (crc_mode),
    .abort     (abort),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [MAX_W-1:0] rand_data();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[MAX_W-1:0];
  endfunction

  // x^5 + x^2 + 1, MSB-first
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic       fb;
    logic [4:0] n;
    fb   = b ^ c[4];
    n[0] = fb;
    n[1] = c[0];
    n[2] = c[1] ^ fb;
    n[3] = c[2];
    n[4] = c[3];
    return n;
  endfunction

  // x^16 + x^15 + x^2 + 1, MSB-first
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic        fb;
    logic [15:0] n;
    fb      = b ^ c[15];
    n[0]    = fb;
    n[1]    = c[0];
    n[2]    = c[1] ^ fb;
    n[14:3] = c[13:2];
    n[15]   = c[14] ^ fb;
    return n;
  endfunction

  function automatic int push_pkt(input logic [MAX_W-1:0] d, input int l, input int sk,
                                  input logic [1:0] m);
    int          le;
    int          cnt;
    logic        b;
    logic [4:0]  c5;
    logic [15:0] c16;
    le  = (l > MAX_W) ? MAX_W : l;
    cnt = 0;
    c5  = 5'h1F;
    c16 = 16'hFFFF;
    for (int i = 0; i < le; i++) begin
      b = d[le-1-i];
      exp_q.push_back(b);
      cnt++;
      if (i >= sk) begin
        c5  = crc5_step(c5, b);
        c16 = crc16_step(c16, b);
      end
    end
    if (CRC_EN && (m == 2'b01)) begin
      for (int k = 4; k >= 0; k--) exp_q.push_back(~c5[k]);
      cnt += 5;
    end else if (CRC_EN && (m == 2'b10)) begin
      for (int k = 15; k >= 0; k--) exp_q.push_back(~c16[k]);
      cnt += 16;
    end
    return cnt;
  endfunction

  task automatic check_idle_outs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_valid"}, bit_valid, 0);
    check({tag, "_bit_out"}, bit_out, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Entered and left at posedge+1.
  task automatic idle_check(input int cycles, input string tag);
    repeat (cycles) begin
      @(negedge clk);
      check_idle_outs(tag);
      @(posedge clk); #1;
    end
  endtask

  // Entered and left at posedge+1. Cycle n=1 is the first cycle after accept.
  task automatic run_pkt(input logic [MAX_W-1:0] d, input int l, input int sk,
                         input logic [1:0] m, input int abort_at = 0,
                         input int busy_at = 0, input int rst_at = 0);
    int total;
    bit done_seen;
    bit stop;
    done_seen = 1'b0;
    stop      = 1'b0;
    total     = push_pkt(d, l, sk, m);
    data      = d;
    len       = LEN_W'(l);
    crc_skip  = LEN_W'(sk);
    crc_mode  = m;
    load      = 1'b1;
    @(posedge clk); #1;
    load      = 1'b0;
    data      = rand_data();
    len       = LEN_W'($urandom);
    crc_skip  = LEN_W'($urandom);
    crc_mode  = 2'($urandom);
    for (int n = 1; n <= total + 4 && !done_seen && !stop; n++) begin
      abort = (n == abort_at);
      load  = (n == busy_at);
      @(negedge clk);
      if (n == rst_at) begin
        rst_b = 1'b0;
        #1;
        check_idle_outs("rst_mid");
        exp_q.delete();
        @(posedge clk); #1;
        rst_b = 1'b1;
        stop  = 1'b1;
      end else if (abort_at > 0 && n == abort_at + 1) begin
        check_idle_outs("abort_next");
        exp_q.delete();
        @(posedge clk); #1;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
          check("abort_no_valid", bit_valid, 0);
          @(posedge clk); #1;
        end
        stop = 1'b1;
      end else begin
        if (bit_valid) begin
          if (exp_q.size() == 0) check("extra_bit", bit_valid, 0);
          else check("bit", bit_out, exp_q.pop_front());
        end else if (done) begin
          check("done_cycle", n, total + 1);
          check("bits_left", exp_q.size(), 0);
          check("bit_out_at_done", bit_out, 0);
          done_seen = 1'b1;
        end else begin
          check("valid_gap", bit_valid, 1);
        end
        @(posedge clk); #1;
      end
    end
    abort = 1'b0;
    load  = 1'b0;
    if (!stop) begin
      check("done_seen", done_seen, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("ready_after_done", ready, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [MAX_W-1:0] d;
    rst_b    = 1'b0;
    load     = 1'b0;
    abort    = 1'b0;
    data     = '0;
    len      = '0;
    crc_skip = '0;
    crc_mode = 2'b00;
    #3;
    check_idle_outs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle_check(1, "post_reset");

    d = rand_data(); d[7:0] = 8'b10000111;
    run_pkt(d, 8, 0, 2'b00);

    d = rand_data(); d[15:0] = 16'h80C3;
    run_pkt(d, 16, 16, 2'b10);

    d = rand_data(); d[18:11] = 8'h69;
    run_pkt(d, 19, 8, 2'b01);

    run_pkt(rand_data(), 40, 8, 2'b10);
    run_pkt(rand_data(), 24, 0, 2'b11);
    run_pkt(rand_data(), 120, 4, 2'b01);
    run_pkt(rand_data(), 10, 12, 2'b01);
    run_pkt(rand_data(), 1, 0, 2'b00);

    run_pkt(rand_data(), 32, 0, 2'b10, 4, 0, 0);

    data = rand_data(); len = '0; crc_skip = '0; crc_mode = 2'b00; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    idle_check(3, "len0");

    data = rand_data(); len = LEN_W'(8); load = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; abort = 1'b0;
    idle_check(3, "load_abort");

    run_pkt(rand_data(), 12, 0, 2'b01, 0, 3, 0);

    run_pkt(rand_data(), 8, 0, 2'b10, 0, 0, CRC_EN ? 12 : 5);
    idle_check(2, "after_rst");
    d = rand_data(); d[7:0] = 8'b01101001;
    run_pkt(d, 8, 0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
